// File: rtl/data_conv_pkg.sv
// Shared definitions for the 64<->8 bit data converters: FSM state codes,
// byte count and byte-index width.
package data_conv_pkg;

  localparam int BYTE_NUM = 8;
  localparam int IDX_W    = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  typedef logic [IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Single-register rising-edge detector. The arm flag suppresses a bogus
// event when the input is already high as reset releases.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic in_q;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_q  <= in;
      armed <= 1'b1;
    end
  end

  assign pulse = in & ~in_q & armed;

endmodule

// File: rtl/data_in_64_to_8.sv
// Serializes a 64-bit word into 8 bytes for a UART transmitter, handshaking
// on tx_done. Define DATA_IN_MSB_FIRST_EN to send data_64[63:56] first.
module data_in_64_to_8
  import data_conv_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_64,
  input  logic        data_64_valid,
  input  logic        tx_done,
  output logic [7:0]  data_8,
  output logic        tx_start,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic [1:0]  state;
  logic [63:0] shadow;
  byte_idx_t   idx;
  logic [3:0]  gap_cnt;
  logic        load_ev;
  logic        done_ev;

  function automatic logic [7:0] byte_sel(input logic [63:0] w, input byte_idx_t i);
`ifdef DATA_IN_MSB_FIRST_EN
    return w[{~i, 3'b000} +: 8];
`else
    return w[{i, 3'b000} +: 8];
`endif
  endfunction

  rise_edge_detect u_load_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (data_64_valid),
    .pulse (load_ev)
  );

  rise_edge_detect u_done_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (tx_done),
    .pulse (done_ev)
  );

  assign tx_start = (state == ST_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shadow     <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      data_8     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      // The frame_done cycle still counts as part of the frame for loads.
      if (load_ev && (state != ST_IDLE || frame_done))
        overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (load_ev && !frame_done) begin
            shadow <= data_64;
            idx    <= '0;
            data_8 <= byte_sel(data_64, '0);
            busy   <= 1'b1;
            state  <= ST_SEND;
          end
        end
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (done_ev) begin
            if (idx == byte_idx_t'(BYTE_NUM - 1)) begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              idx <= idx + 3'd1;
              if (GAP_CYCLES == 0) begin
                data_8 <= byte_sel(shadow, idx + 3'd1);
                state  <= ST_SEND;
              end else begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            data_8 <= byte_sel(shadow, idx);
            state  <= ST_SEND;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_in_64_to_8.sv
// Bench: two instances (GAP_CYCLES=2 and 0) driven by a transmitter model,
// checked against a byte-order reference computed from the word.
module tb_data_in_64_to_8;

`ifdef DATA_IN_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] d64 [2];
  logic        vld [2];
  logic        txd [2];
  logic [7:0]  d8  [2];
  logic        ts  [2];
  logic        bz  [2];
  logic        fd  [2];
  logic        ov  [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_in_64_to_8 #(.GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_64(d64[0]), .data_64_valid(vld[0]),
    .tx_done(txd[0]), .data_8(d8[0]), .tx_start(ts[0]), .busy(bz[0]),
    .frame_done(fd[0]), .overrun(ov[0]));

  data_in_64_to_8 #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_64(d64[1]), .data_64_valid(vld[1]),
    .tx_done(txd[1]), .data_8(d8[1]), .tx_start(ts[1]), .busy(bz[1]),
    .frame_done(fd[1]), .overrun(ov[1]));

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int k);
    int sh;
    sh = MSB ? 8 * (7 - k) : 8 * k;
    return 8'((w >> sh) & 64'hFF);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int s, output int k);
    k = 0;
    while (ts[s] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  typedef struct {
    int          sel;
    logic [63:0] word;
    int          dly;
    int          ovr_b;
    int          glitch_b;
    int          abort_b;
    bit          load_fd;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
  } vec_t;

  // One frame through instance s; tx_done rises d cycles after each tx_start.
  task automatic run_frame(input int s, input logic [63:0] w, input int d,
                           input int ovr_b, input int glitch_b, input int abort_b,
                           input bit load_fd, output logic [7:0] first,
                           output logic [7:0] last);
    int g, k, used;
    g = (s == 0) ? 2 : 0;
    used = 0;
    first = 8'h00;
    last = 8'h00;
    @(negedge clk);
    d64[s] = w;
    vld[s] = 1'b1;
    @(negedge clk);
    vld[s] = 1'b0;
    d64[s] = ~w;
    chk("busy_after_load", 64'(bz[s]), 64'd1);
    for (int b = 0; b < 8; b++) begin
      wait_start(s, k);
      chk("start_latency", 64'(k), 64'((b == 0) ? 0 : g - used));
      if (k >= 40) return;
      used = 0;
      chk("byte_value", 64'(d8[s]), 64'(byte_of(w, b)));
      if (b == 0) first = d8[s];
      last = d8[s];
      if (b == abort_b) begin
        @(negedge clk);
        rst_n = 1'b0;
        vld[s] = 1'b1;
        #1;
        chk("reset_outputs", {d8[s], ts[s], bz[s], fd[s], ov[s]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_load_at_release_1", {ts[s], bz[s]}, 64'd0);
        @(negedge clk);
        chk("no_load_at_release_2", {ts[s], bz[s]}, 64'd0);
        vld[s] = 1'b0;
        return;
      end
      for (int c = 1; c < d; c++) begin
        @(negedge clk);
        if (c == 1) chk("tx_start_one_cycle", 64'(ts[s]), 64'd0);
        chk("data_8_stable", 64'(d8[s]), 64'(byte_of(w, b)));
        if (b == ovr_b) begin
          if (c == 1) begin
            d64[s] = 64'hFFFF_FFFF_FFFF_FFFF;
            vld[s] = 1'b1;
          end else if (c == 2) begin
            vld[s] = 1'b0;
            chk("overrun_pulse", 64'(ov[s]), 64'd1);
          end else if (c == 3) begin
            chk("overrun_clears", 64'(ov[s]), 64'd0);
          end
        end
      end
      @(negedge clk);
      txd[s] = 1'b1;
      @(negedge clk);
      txd[s] = 1'b0;
      if (b == 7) begin
        chk("frame_done_pulse", 64'(fd[s]), 64'd1);
        chk("busy_low_at_end", 64'(bz[s]), 64'd0);
        if (load_fd) begin
          vld[s] = 1'b1;
          @(negedge clk);
          vld[s] = 1'b0;
          chk("overrun_in_frame_done", 64'(ov[s]), 64'd1);
          chk("no_start_after_fd_load", {ts[s], bz[s]}, 64'd0);
          @(negedge clk);
          chk("still_idle_after_fd_load", {ts[s], bz[s]}, 64'd0);
        end
        @(negedge clk);
        chk("frame_done_clears", 64'(fd[s]), 64'd0);
      end else begin
        chk("no_frame_done_mid", 64'(fd[s]), 64'd0);
        chk("busy_mid_frame", 64'(bz[s]), 64'd1);
        if (b == glitch_b && g == 2) begin
          @(negedge clk);
          txd[s] = 1'b1;
          chk("no_start_in_gap", 64'(ts[s]), 64'd0);
          @(negedge clk);
          txd[s] = 1'b0;
          used = 2;
        end
      end
    end
  endtask

  vec_t vecs [7];

  initial begin
    logic [7:0] f, l;
    logic [63:0] rw;
    int rd, rs;
    for (int i = 0; i < 2; i++) begin
      d64[i] = '0; vld[i] = 1'b0; txd[i] = 1'b0;
    end
    vecs[0] = '{0, 64'h8877_6655_4433_2211, 5, -1, -1, -1, 1'b0, MSB ? 8'h88 : 8'h11, MSB ? 8'h11 : 8'h88};
    vecs[1] = '{0, 64'h8877_6655_4433_2211, 5,  3, -1, -1, 1'b0, MSB ? 8'h88 : 8'h11, MSB ? 8'h11 : 8'h88};
    vecs[2] = '{0, 64'h1122_3344_5566_7788, 4, -1,  2, -1, 1'b1, MSB ? 8'h11 : 8'h88, MSB ? 8'h88 : 8'h11};
    vecs[3] = '{0, 64'hDEAD_BEEF_CAFE_F00D, 3, -1, -1,  4, 1'b0, MSB ? 8'hDE : 8'h0D, MSB ? 8'hCA : 8'hEF};
    vecs[4] = '{0, 64'h0102_0304_0506_0708, 3, -1, -1, -1, 1'b0, MSB ? 8'h01 : 8'h08, MSB ? 8'h08 : 8'h01};
    vecs[5] = '{1, 64'h8877_6655_4433_2211, 1, -1, -1, -1, 1'b0, MSB ? 8'h88 : 8'h11, MSB ? 8'h11 : 8'h88};
    vecs[6] = '{1, 64'h0102_0304_0506_0708, 2, -1, -1, -1, 1'b1, MSB ? 8'h01 : 8'h08, MSB ? 8'h08 : 8'h01};

    #1;
    chk("reset_state_dut2", {d8[0], ts[0], bz[0], fd[0], ov[0]}, 64'd0);
    chk("reset_state_dut0", {d8[1], ts[1], bz[1], fd[1], ov[1]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].sel, vecs[i].word, vecs[i].dly, vecs[i].ovr_b,
                vecs[i].glitch_b, vecs[i].abort_b, vecs[i].load_fd, f, l);
      chk("vec_first_byte", 64'(f), 64'(vecs[i].exp_first));
      chk("vec_last_byte", 64'(l), 64'(vecs[i].exp_last));
    end

    // tx_done while idle must not start anything
    @(negedge clk);
    txd[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      txd[0] = 1'b0;
      chk("idle_tx_done_ignored", {ts[0], bz[0], fd[0]}, 64'd0);
    end

    for (int i = 0; i < 8; i++) begin
      rw = {$urandom, $urandom};
      rd = int'($urandom_range(1, 6));
      rs = i % 2;
      run_frame(rs, rw, rd, -1, -1, -1, 1'b0, f, l);
      chk("rand_first", 64'(f), 64'(byte_of(rw, 0)));
      chk("rand_last", 64'(l), 64'(byte_of(rw, 7)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
